// File: rtl/round_sequencer.sv
// Bomb-defusal round sequencer: code generation, display, armed countdown with
// code entry, then a defused/exploded result with optional automatic restart.
module round_sequencer #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned SHOW_SEC    = 3,
    parameter int unsigned ARM_SEC     = 20,
    parameter int unsigned RESULT_SEC  = 3,
    parameter int unsigned MAX_STRIKES = 3,
    parameter int unsigned AUTO_REPEAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       master_en,
    input  logic       start_btn,
    input  logic       code_ok,
    input  logic       code_bad,
    output logic [4:0] code,
    output logic       show_en,
    output logic       input_en,
    output logic       bomb_en,
    output logic [4:0] countdown,
    output logic [2:0] strikes,
    output logic       defused,
    output logic       exploded
);

    localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_SEC = (SHOW_SEC > RESULT_SEC) ? SHOW_SEC : RESULT_SEC;
    localparam int unsigned SW      = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHOW     = 3'd1,
        ST_ARM      = 3'd2,
        ST_DEFUSED  = 3'd3,
        ST_EXPLODED = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [SW-1:0] sec_cnt, sec_nxt;
    logic [4:0]    lfsr, lfsr_nxt;
    logic          start_q;
    logic          sec_tick;
    logic          start_edge;

    logic [4:0]    code_nxt;
    logic          show_nxt;
    logic          input_nxt;
    logic          bomb_nxt;
    logic [4:0]    countdown_nxt;
    logic [2:0]    strikes_nxt;
    logic          defused_nxt;
    logic          exploded_nxt;

    // Next-state, timing and output decode
    always_comb begin
        sec_tick      = (presc == PW'(TICK_DIV - 1));
        start_edge    = start_btn & ~start_q;
        lfsr_nxt      = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        state_nxt     = state;
        code_nxt      = code;
        countdown_nxt = countdown;
        strikes_nxt   = strikes;
        sec_nxt       = sec_cnt;
        presc_nxt     = sec_tick ? '0 : presc + PW'(1);

        case (state)
            ST_IDLE: begin
                if (master_en && start_edge) begin
                    state_nxt     = ST_SHOW;
                    code_nxt      = lfsr;
                    strikes_nxt   = '0;
                    countdown_nxt = '0;
                end
            end
            ST_SHOW: begin
                if (sec_tick) begin
                    if (sec_cnt == SW'(SHOW_SEC - 1)) begin
                        state_nxt     = ST_ARM;
                        countdown_nxt = 5'(ARM_SEC);
                    end else begin
                        sec_nxt = sec_cnt + SW'(1);
                    end
                end
            end
            ST_ARM: begin
                // A correct code wins outright and freezes the countdown
                if (code_ok) begin
                    state_nxt = ST_DEFUSED;
                end else begin
                    if (code_bad && (strikes < 3'(MAX_STRIKES))) begin
                        strikes_nxt = strikes + 3'd1;
                        if (strikes == 3'(MAX_STRIKES - 1)) begin
                            state_nxt = ST_EXPLODED;
                        end
                    end
                    if (sec_tick && (countdown != 5'd0)) begin
                        countdown_nxt = countdown - 5'd1;
                        if (countdown == 5'd1) begin
                            state_nxt = ST_EXPLODED;
                        end
                    end
                end
            end
            ST_DEFUSED, ST_EXPLODED: begin
                if (sec_tick) begin
                    if (sec_cnt == SW'(RESULT_SEC - 1)) begin
                        strikes_nxt   = '0;
                        countdown_nxt = '0;
                        if (AUTO_REPEAT != 0) begin
                            state_nxt = ST_SHOW;
                            code_nxt  = lfsr;
                        end else begin
                            state_nxt = ST_IDLE;
                            code_nxt  = '0;
                        end
                    end else begin
                        sec_nxt = sec_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Master switch overrides everything and abandons the round
        if (!master_en) begin
            state_nxt     = ST_IDLE;
            code_nxt      = '0;
            countdown_nxt = '0;
            strikes_nxt   = '0;
        end

        // Each phase starts with a fresh second so its length is exact
        if (state_nxt != state) begin
            presc_nxt = '0;
            sec_nxt   = '0;
        end

        show_nxt     = (state_nxt == ST_SHOW);
        input_nxt    = (state_nxt == ST_ARM);
        bomb_nxt     = (state_nxt == ST_SHOW) || (state_nxt == ST_ARM);
        defused_nxt  = (state_nxt == ST_DEFUSED);
        exploded_nxt = (state_nxt == ST_EXPLODED);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            presc     <= '0;
            sec_cnt   <= '0;
            lfsr      <= 5'b00001;
            start_q   <= 1'b0;
            code      <= '0;
            show_en   <= 1'b0;
            input_en  <= 1'b0;
            bomb_en   <= 1'b0;
            countdown <= '0;
            strikes   <= '0;
            defused   <= 1'b0;
            exploded  <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            sec_cnt   <= sec_nxt;
            lfsr      <= lfsr_nxt;
            start_q   <= start_btn;
            code      <= code_nxt;
            show_en   <= show_nxt;
            input_en  <= input_nxt;
            bomb_en   <= bomb_nxt;
            countdown <= countdown_nxt;
            strikes   <= strikes_nxt;
            defused   <= defused_nxt;
            exploded  <= exploded_nxt;
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: a phase/elapsed-time reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_round_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int SHOW_SEC    = 2;
    localparam int ARM_SEC     = 3;
    localparam int RESULT_SEC  = 1;
    localparam int MAX_STRIKES = 3;
    localparam int AUTO_REPEAT = 1;

    typedef struct packed {
        logic [4:0] code;
        logic       show_en;
        logic       input_en;
        logic       bomb_en;
        logic [4:0] countdown;
        logic [2:0] strikes;
        logic       defused;
        logic       exploded;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       master_en = 1'b0;
    logic       start_btn = 1'b0;
    logic       code_ok = 1'b0;
    logic       code_bad = 1'b0;
    logic [4:0] code;
    logic       show_en;
    logic       input_en;
    logic       bomb_en;
    logic [4:0] countdown;
    logic [2:0] strikes;
    logic       defused;
    logic       exploded;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    outs_t exp_q[$];
    int    tag_q[$];

    // Reference model: phase 0 idle, 1 show, 2 arm, 3 defused, 4 exploded
    int m_phase = 0;
    int m_elapsed = 0;
    int m_lfsr = 1;
    bit m_prev = 1'b0;
    int m_code = 0;
    int m_count = 0;
    int m_strikes = 0;

    round_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .SHOW_SEC   (SHOW_SEC),
        .ARM_SEC    (ARM_SEC),
        .RESULT_SEC (RESULT_SEC),
        .MAX_STRIKES(MAX_STRIKES),
        .AUTO_REPEAT(AUTO_REPEAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .master_en(master_en),
        .start_btn(start_btn),
        .code_ok  (code_ok),
        .code_bad (code_bad),
        .code     (code),
        .show_en  (show_en),
        .input_en (input_en),
        .bomb_en  (bomb_en),
        .countdown(countdown),
        .strikes  (strikes),
        .defused  (defused),
        .exploded (exploded)
    );

    always #5 clk = ~clk;

    function automatic outs_t outs_now();
        return {code, show_en, input_en, bomb_en, countdown, strikes, defused, exploded};
    endfunction

    task automatic model_step(input bit r, input bit m, input bit b, input bit ok, input bit bad);
        int  nph;
        int  done;
        bit  edge_s;
        if (!r) begin
            m_phase = 0; m_elapsed = 0; m_lfsr = 1; m_prev = 1'b0;
            m_code = 0; m_count = 0; m_strikes = 0;
        end else begin
            edge_s = b && !m_prev;
            done   = m_elapsed + 1;
            nph    = m_phase;
            case (m_phase)
                0: if (m && edge_s) begin
                    nph = 1; m_code = m_lfsr; m_strikes = 0; m_count = 0;
                end
                1: if (done == SHOW_SEC * TICK_DIV) begin
                    nph = 2; m_count = ARM_SEC;
                end
                2: if (ok) begin
                    nph = 3;
                end else begin
                    if (bad) begin
                        m_strikes++;
                        if (m_strikes >= MAX_STRIKES) nph = 4;
                    end
                    if (done % TICK_DIV == 0) m_count = ARM_SEC - done / TICK_DIV;
                    if (done == ARM_SEC * TICK_DIV) nph = 4;
                end
                default: if (done == RESULT_SEC * TICK_DIV) begin
                    nph = (AUTO_REPEAT != 0) ? 1 : 0;
                    m_code = (AUTO_REPEAT != 0) ? m_lfsr : 0;
                    m_strikes = 0; m_count = 0;
                end
            endcase
            if (!m) begin
                nph = 0; m_code = 0; m_count = 0; m_strikes = 0;
            end
            m_elapsed = (nph != m_phase) ? 0 : done;
            m_phase   = nph;
            m_lfsr    = ((m_lfsr << 1) & 31) | (((m_lfsr >> 4) ^ (m_lfsr >> 2)) & 1);
            m_prev    = b;
        end
    endtask

    function automatic outs_t model_outs();
        outs_t o;
        o.code      = 5'(m_code);
        o.show_en   = (m_phase == 1);
        o.input_en  = (m_phase == 2);
        o.bomb_en   = (m_phase == 1) || (m_phase == 2);
        o.countdown = 5'(m_count);
        o.strikes   = 3'(m_strikes);
        o.defused   = (m_phase == 3);
        o.exploded  = (m_phase == 4);
        return o;
    endfunction

    // One clock of stimulus: drive at negedge, predict the next edge, queue it
    task automatic cyc(input bit r, input bit m, input bit b, input bit ok, input bit bad);
        @(negedge clk);
        rst_n = r; master_en = m; start_btn = b; code_ok = ok; code_bad = bad;
        model_step(r, m, b, ok, bad);
        exp_q.push_back(model_outs());
        tag_q.push_back(cyc_n);
        cyc_n++;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic spot(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard monitor
    initial begin
        outs_t e;
        outs_t a;
        int    t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = outs_now();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL scoreboard cyc=%0d got code=%0d show=%0b in=%0b bomb=%0b cd=%0d str=%0d def=%0b exp=%0b required code=%0d show=%0b in=%0b bomb=%0b cd=%0d str=%0d def=%0b exp=%0b",
                             t, a.code, a.show_en, a.input_en, a.bomb_en, a.countdown, a.strikes,
                             a.defused, a.exploded, e.code, e.show_en, e.input_en, e.bomb_en,
                             e.countdown, e.strikes, e.defused, e.exploded);
                end
            end
        end
    end

    initial begin
        bit rb;
        bit mb;
        bit bb;
        bit okb;
        bit badb;

        // Reset, then idle with no start
        repeat (3) cyc(0, 0, 0, 0, 0);
        settle(); spot("reset_outs", int'(outs_now()), 0);
        repeat (4) cyc(1, 0, 0, 0, 0);
        settle(); spot("idle_outs", int'(outs_now()), 0);

        // Start edge, 8 cycles of SHOW, then ARM at 3
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        settle(); spot("show_start", int'(show_en), 1); spot("code_latched", int'(code), m_code);
        repeat (7) cyc(1, 1, 1, 0, 0);
        settle(); spot("show_last", int'(show_en), 1);
        cyc(1, 1, 1, 0, 0);
        settle(); spot("arm_input_en", int'(input_en), 1); spot("arm_countdown", int'(countdown), 3);

        // Untouched countdown explodes, then auto-restart
        repeat (11) cyc(1, 1, 0, 0, 0);
        settle(); spot("cd_last_sec", int'(countdown), 1);
        cyc(1, 1, 0, 0, 0);
        settle(); spot("timeout_exploded", int'(exploded), 1);
        spot("timeout_cd", int'(countdown), 0); spot("timeout_bomb", int'(bomb_en), 0);
        repeat (4) cyc(1, 1, 0, 0, 0);
        settle(); spot("auto_show", int'(show_en), 1);

        // Defuse at ARM cycle 5, later code_bad ignored
        repeat (8) cyc(1, 1, 0, 0, 0);
        repeat (4) cyc(1, 1, 0, 0, 0);
        settle(); spot("cd_two", int'(countdown), 2);
        cyc(1, 1, 0, 1, 0);
        settle(); spot("defused", int'(defused), 1);
        spot("cd_frozen", int'(countdown), 2); spot("defused_input_off", int'(input_en), 0);
        cyc(1, 1, 0, 0, 1);
        settle(); spot("bad_after_defuse", int'(strikes), 0);
        repeat (3) cyc(1, 1, 0, 0, 0);

        // Three strikes
        repeat (8) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        settle(); spot("strike1", int'(strikes), 1);
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 1);
        settle(); spot("strike2", int'(strikes), 2);
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 1);
        settle(); spot("strike3", int'(strikes), 3); spot("strike_exploded", int'(exploded), 1);
        repeat (4) cyc(1, 1, 0, 0, 0);

        // code_ok and code_bad together
        repeat (8) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 1);
        settle(); spot("okbad_defused", int'(defused), 1); spot("okbad_strikes", int'(strikes), 0);
        repeat (4) cyc(1, 1, 0, 0, 0);

        // Master off mid-ARM with button held, then fresh edge required
        repeat (8) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        settle(); spot("arm_ignores_start", int'(input_en), 1);
        cyc(1, 0, 1, 0, 0);
        settle(); spot("master_off", int'(outs_now()), 0);
        repeat (5) cyc(1, 1, 1, 0, 0);
        settle(); spot("held_btn_idle", int'(outs_now()), 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        settle(); spot("fresh_edge_show", int'(show_en), 1);

        // Randomized traffic against the model
        bb = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rb   = ($urandom_range(0, 999) != 0);
            mb   = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 9) == 0) bb = ~bb;
            okb  = ($urandom_range(0, 39) == 0);
            badb = ($urandom_range(0, 14) == 0);
            cyc(rb, mb, bb, okb, badb);
        end
        cyc(1, 1, 0, 0, 0);

        @(posedge clk);
        #3;
        spot("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
